// File: rtl/mac_tile_dual.sv
// mac_tile_dual: systolic MAC tile with weight-stationary and output-stationary dataflows
module mac_tile_dual #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int SAT     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [bw-1:0]      in_w,
    output logic [bw-1:0]      out_e,
    input  logic [psum_bw-1:0] in_n,
    output logic [psum_bw-1:0] out_s,
    input  logic [2:0]         inst_w,
    output logic [2:0]         inst_e
);
    logic signed [bw-1:0]      a_q, b_q;
    logic signed [psum_bw-1:0] c_q, acc_q;
    logic [2:0]                inst_q;
    logic                      load_ready_q, drain_q;
    logic signed [2*bw-1:0]    w_prod;
    logic [psum_bw:0]          w_prod_x, w_ws_sum, w_os_sum;

    // One guard bit above psum_bw exposes overflow as a mismatch of the top two bits
    function automatic logic [psum_bw-1:0] f(input logic [psum_bw:0] s);
        if (SAT != 0 && s[psum_bw] != s[psum_bw-1])
            return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        return s[psum_bw-1:0];
    endfunction

    // Full-precision product, sign-extended sums for both dataflows, output select
    always_comb begin
        w_prod   = a_q * b_q;
        w_prod_x = {{(psum_bw+1-2*bw){w_prod[2*bw-1]}}, w_prod};
        w_ws_sum = w_prod_x + {c_q[psum_bw-1], c_q};
        w_os_sum = w_prod_x + {acc_q[psum_bw-1], acc_q};
        out_s    = mode ? (drain_q ? acc_q : {{(psum_bw-bw){b_q[bw-1]}}, b_q}) : f(w_ws_sum);
    end

    assign out_e  = a_q;
    assign inst_e = inst_q;

    // Tile state; in WS only the first weight after a clear is captured, in OS a drain restarts accumulation from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            acc_q        <= '0;
            inst_q       <= '0;
            drain_q      <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            if (inst_w[0] | inst_w[1]) a_q <= in_w;
            inst_q[2:1] <= inst_w[2:1];
            drain_q     <= mode & inst_w[2];
            if (!mode) begin
                if (inst_w[1]) c_q <= in_n;
                if (inst_w[2]) begin
                    b_q          <= '0;
                    load_ready_q <= 1'b1;
                    inst_q[0]    <= inst_w[0];
                end else begin
                    if (inst_w[0] && load_ready_q) begin
                        b_q          <= in_w;
                        load_ready_q <= 1'b0;
                    end
                    if (!load_ready_q) inst_q[0] <= inst_w[0];
                end
            end else begin
                if (inst_w[1]) b_q <= in_n[bw-1:0];
                inst_q[0] <= inst_w[0];
                if (drain_q) acc_q <= inst_q[1] ? f(w_prod_x) : '0;
                else if (inst_q[1]) acc_q <= f(w_os_sum);
            end
        end
    end
endmodule

// File: tb/tb_mac_tile_dual.sv
// tb_mac_tile_dual: directed scoreboard bench for wrap and saturating tiles
module tb_mac_tile_dual;
    logic        clk = 1'b0;
    logic        reset, mode;
    logic [3:0]  in_w, out_e, out_e1;
    logic [15:0] in_n, out_s0, out_s1;
    logic [2:0]  inst_w, inst_e, inst_e1;
    int          total = 0, bad = 0;

    typedef struct {string tag; int sel; logic [15:0] v;} item_t;
    item_t sb[$];

    mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(0)) dut0 (
        .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e),
        .in_n(in_n), .out_s(out_s0), .inst_w(inst_w), .inst_e(inst_e));
    mac_tile_dual #(.bw(4), .psum_bw(16), .SAT(1)) dut1 (
        .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .out_e(out_e1),
        .in_n(in_n), .out_s(out_s1), .inst_w(inst_w), .inst_e(inst_e1));

    always #5 clk = ~clk;

    task automatic push(string t, int s, int v);
        item_t it;
        it.tag = t;
        it.sel = s;
        it.v   = 16'(v);
        sb.push_back(it);
    endtask

    task automatic es(string t, int v0, int v1);
        push({t, "/wrap"}, 0, v0);
        push({t, "/sat"}, 1, v1);
    endtask

    task automatic eo(string t, int e, int i);
        push({t, "/out_e"}, 2, e & 15);
        push({t, "/inst_e"}, 3, i);
    endtask

    task automatic check_all();
        item_t it;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            it  = sb.pop_front();
            obs = it.sel == 0 ? out_s0 : it.sel == 1 ? out_s1 : it.sel == 2 ? 16'(out_e) : 16'(inst_e);
            total++;
            assert (obs === it.v) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", it.tag, $signed(obs), $signed(it.v));
            end
        end
    endtask

    task automatic drive(logic [2:0] i, int w, int n);
        inst_w = i;
        in_w   = 4'(w);
        in_n   = 16'(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        drive(3'b000, 0, 0);
        #12;
        es("reset", 0, 0); eo("reset", 0, 0);
        check_all();
        reset = 1'b0;

        drive(3'b001, 3, 0);       tick_exp_load1();
        drive(3'b001, 5, 0);       es("ws_load2", 15, 15); eo("ws_load2", 5, 1); tick();
        drive(3'b010, -2, 10);     es("ws_exec", 4, 4); eo("ws_exec", -2, 2); tick();
        drive(3'b100, 0, 0);       es("ws_clear", 10, 10); eo("ws_clear", -2, 4); tick();
        drive(3'b001, 6, 0);       es("ws_reload", 46, 46); eo("ws_reload", 6, 0); tick();
        drive(3'b010, 1, 0);       es("ws_reload_exec", 6, 6); tick();
        drive(3'b101, 9, 0);       es("ws_clr_ld", 0, 0); eo("ws_clr_ld", 9, 5); tick();
        drive(3'b001, 5, 0);       es("ws_ready_after", 25, 25); eo("ws_ready_after", 5, 1); tick();
        drive(3'b100, 0, 0);       es("ws_clear2", 0, 0); tick();
        drive(3'b001, 7, 0);       es("ws_load7", 49, 49); tick();
        drive(3'b010, 7, 32767);   es("sat_pos", -32720, 32767); tick();
        drive(3'b010, -8, -32768); es("sat_neg", 32712, -32768); tick();

        drive(3'b000, 0, 0);
        reset = 1'b1;
        mode  = 1'b1;
        #1;
        es("os_reset", 0, 0); eo("os_reset", 0, 0);
        check_all();
        #2 reset = 1'b0;

        drive(3'b010, 2, 3);       es("os_exec1", 3, 3); eo("os_exec1", 2, 2); tick();
        tick();
        tick();
        drive(3'b000, 0, 0);       eo("os_idle", 2, 0); tick();
        drive(3'b100, 0, 0);       es("os_drain", 18, 18); eo("os_drain", 2, 4); tick();
        drive(3'b000, 0, 0);       es("os_after_drain", 3, 3); tick();
        drive(3'b100, 0, 0);       es("os_acc_zero", 0, 0); tick();
        drive(3'b110, 1, 2);       es("os_drain_exec", 0, 0); tick();
        drive(3'b000, 0, 0);       es("os_bfwd", 2, 2); tick();
        drive(3'b100, 0, 0);       es("os_restart", 2, 2); tick();
        drive(3'b000, 0, 0);       tick();

        drive(3'b010, 2, 3);       tick();
        tick();
        #3 reset = 1'b1;
        #1;
        es("async_rst", 0, 0); eo("async_rst", 0, 0);
        check_all();
        drive(3'b000, 0, 0);
        #1 reset = 1'b0;
        tick();
        drive(3'b100, 0, 0);       es("rst_acc_zero", 0, 0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic tick_exp_load1();
        eo("ws_load1", 3, 0);
        tick();
    endtask
endmodule
